// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller:
// FSM states, opcodes, ALU operations and datapath mux selects.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL
    } state_t;

    // Which family of ALU operation the current state needs.
    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_BRANCH,
        CLS_OP
    } alu_cls_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_OR   = 4'b1100;
    localparam logic [3:0] ALU_AND  = 4'b1110;
    localparam logic [3:0] ALU_SRA  = 4'b1111;
    localparam logic [3:0] ALU_SLTU = 4'b1011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    // Immediate format implied by the opcode; R-type and unknown give 0.
    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        logic [2:0] sel;
        sel = IMM_I;
        case (op)
            OP_STORE:  sel = IMM_S;
            OP_BRANCH: sel = IMM_B;
            OP_JAL:    sel = IMM_J;
            default:   sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder, driven by the class of
// operation the controller state needs plus the instruction fields.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_cls_t    cls_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic        op5_i,
    output logic [3:0]  alu_control_o
);

    // Select ALU op: plain add, branch compare, or full funct3 decode.
    always_comb begin
        alu_control_o = ALU_ADD;
        unique case (cls_i)
            CLS_BRANCH: begin
                case (funct3_i[2:1])
                    2'b10:   alu_control_o = ALU_SLT;
                    2'b11:   alu_control_o = ALU_SLTU;
                    default: alu_control_o = ALU_SUB;
                endcase
            end
            CLS_OP: begin
                case (funct3_i)
                    3'b000: alu_control_o =
                        (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_control_o = ALU_SLL;
                    3'b010: alu_control_o = ALU_SLT;
                    3'b011: alu_control_o = ALU_SLTU;
                    3'b100: alu_control_o = ALU_XOR;
                    3'b101: alu_control_o =
                        funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110: alu_control_o = ALU_OR;
                    default: alu_control_o = ALU_AND;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RV32I subset datapath
// (lw, sw, R/I ALU ops, conditional branches, jal).
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    input  logic        less_than,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_write,
    output logic        adr_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [2:0]  imm_src,
    output logic [3:0]  alu_control,
    output logic        illegal_op
);

    state_t   state_q;
    state_t   state_d;
    alu_cls_t alu_cls;
    logic     legal_op;
    logic     taken;
    logic     pc_write_s;
    logic     ir_write_s;
    logic     reg_write_s;
    logic     mem_write_s;
    logic     illegal_s;

    assign legal_op = (op == OP_LOAD)   || (op == OP_STORE)  ||
                      (op == OP_RTYPE)  || (op == OP_ITYPE)  ||
                      (op == OP_BRANCH) || (op == OP_JAL);

    // funct3[2] picks the less_than family, funct3[0] inverts,
    // and 010/011 never branch.
    assign taken = funct3[2] ? (less_than ^ funct3[0])
                 : funct3[1] ? 1'b0
                 : (zero ^ funct3[0]);

    // Next-state selection.
    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEMADR;
                    OP_RTYPE:  state_d = S_EXECUTER;
                    OP_ITYPE:  state_d = S_EXECUTEI;
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_JAL:    state_d = S_JAL;
                    default:   state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register; reset drops any in-flight instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-state datapath controls; anything not set stays 0.
    always_comb begin
        pc_write_s  = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        mem_write_s = 1'b0;
        illegal_s   = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        result_src  = RES_ALUOUT;
        imm_src     = IMM_I;
        alu_cls     = CLS_ADD;
        unique case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = legal_op ? imm_sel(op) : IMM_I;
                illegal_s = ~legal_op;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src  = RES_RDATA;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_cls   = CLS_OP;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_cls   = CLS_OP;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_cls    = CLS_BRANCH;
                pc_write_s = taken;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write_s = 1'b1;
            end
            default: begin
                illegal_s = 1'b0;
            end
        endcase
    end

    // Strobes are held low for as long as reset is high.
    assign pc_write   = pc_write_s  & ~reset;
    assign ir_write   = ir_write_s  & ~reset;
    assign reg_write  = reg_write_s & ~reset;
    assign mem_write  = mem_write_s & ~reset;
    assign illegal_op = illegal_s   & ~reset;

    alu_decoder u_alu_decoder (
        .cls_i         (alu_cls),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .op5_i         (op[5]),
        .alu_control_o (alu_control)
    );

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-003 SHALL have port op, input, 7 bits: instruction[6:0] from IR.
REQ-004 SHALL have port funct3, input, 3 bits: instruction[14:12].
REQ-005 SHALL have port funct7b5, input, 1 bit: instruction[30].
REQ-006 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-007 SHALL have port less_than, input, 1 bit: ALU SLT/SLTU flag.
REQ-008 SHALL have ports pc_write, ir_write, reg_write, mem_write, adr_src, output, 1 bit each: datapath strobes and address select (0 = PC, 1 = ALUOut).
REQ-009 SHALL have ports alu_src_a and alu_src_b, output, 2 bits each. A: 00 PC, 01 oldPC, 10 rs1. B: 00 rs2, 01 imm, 10 const 4.
REQ-010 SHALL have port result_src, output, 2 bits: 00 ALUOut, 01 ReadData, 10 ALU result.
REQ-011 SHALL have port imm_src, output, 3 bits: 000 I, 001 S, 010 B, 011 J.
REQ-012 SHALL have port alu_control, output, 4 bits. Encoding: ADD 0000, SUB 0010, SLL 0100, SLT 0110, SRL 1000, XOR 1010, OR 1100, AND 1110, SRA 1111, SLTU 1011.
REQ-013 SHALL have port illegal_op, output, 1 bit: one-cycle pulse on an unsupported opcode.

Function
REQ-014 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL.
REQ-015 SHALL drive in FETCH: adr_src=0, ir_write=1, A=00, B=10, ADD, result_src=10, pc_write=1; next state DECODE.
REQ-016 SHALL drive in DECODE: A=01, B=01, ADD (branch/jump target to ALUOut), imm_src per op. Next state: lw/sw (0000011/0100011) -> MEMADR; R-type 0110011 -> EXECUTER; I-ALU 0010011 -> EXECUTEI; branch 1100011 -> BRANCH; jal 1101111 -> JAL.
REQ-017 SHALL, on any other opcode in DECODE, pulse illegal_op and return to FETCH with no writes.
REQ-018 SHALL drive in MEMADR: A=10, B=01, ADD. Next state: MEMREAD for lw, MEMWRITE for sw.
REQ-019 SHALL drive in MEMREAD: adr_src=1, result_src=00; next state MEMWB.
REQ-020 SHALL drive in MEMWB: result_src=01, reg_write=1; next state FETCH.
REQ-021 SHALL drive in MEMWRITE: adr_src=1, mem_write=1; next state FETCH.
REQ-022 SHALL drive in EXECUTER: A=10, B=00, decoded op. In EXECUTEI: A=10, B=01, decoded op. Both go next to ALUWB.
REQ-023 SHALL drive in ALUWB: result_src=00, reg_write=1; next state FETCH.
REQ-024 SHALL drive in BRANCH: A=10, B=00, result_src=00. funct3 000/001 use SUB with taken=zero/!zero; 100/101 use SLT with taken=less_than/!less_than; 110/111 use SLTU with the same rule. pc_write=taken; next state FETCH.
REQ-025 SHALL treat branch funct3 010/011 as not-taken with SUB, and SHALL NOT pulse illegal_op for them.
REQ-026 SHALL drive in JAL: A=01, B=10, ADD, result_src=00, pc_write=1; next state ALUWB.
REQ-027 SHALL decode ALU ops by funct3: 000 ADD (SUB only when R-type and funct7b5=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (SRA when funct7b5=1, both types), 110 OR, 111 AND.
REQ-028 SHALL produce latencies in cycles: lw 5, sw 4, R/I 4, branch 3, jal 4.
REQ-029 SHALL drive every output not listed for a state to 0.

Reset
REQ-030 SHALL force state to FETCH asynchronously on reset.
REQ-031 SHALL hold pc_write, ir_write, reg_write, mem_write and illegal_op at 0 while reset is high; all other outputs take FETCH values.
REQ-032 SHALL abandon any in-flight instruction on reset mid-instruction, with no further strobes; the first edge after deassertion executes FETCH.

Structure
REQ-033 SHALL take the state enum, opcode constants, ALU encodings and mux encodings from shared package riscv_ctrl_pkg; the ALU SHALL use the same ALU constants.
REQ-034 SHALL instantiate one combinational sub-module, alu_decoder (inputs: state class, funct3, funct7b5, op[5]; output: alu_control).

Verification
REQ-035 Reset asserted mid-MEMREAD -> state FETCH immediately, all strobes 0; after release, FETCH outputs pc_write=1, ir_write=1.
REQ-036 lw (op 0000011) -> 5-cycle sequence; reg_write=1 only in cycle 5 with result_src=01.
REQ-037 R-type funct3=000, funct7b5=1 -> alu_control=0010 in EXECUTER. Same fields as I-type -> 0000.
REQ-038 bltu (funct3=110) with less_than=1 -> alu_control=1011, pc_write=1 in BRANCH. With less_than=0 -> pc_write=0.
REQ-039 bne with zero=1 -> pc_write=0; 3 cycles, then FETCH.
REQ-040 op=1111111 -> illegal_op=1 for one cycle in DECODE, no write strobes, next state FETCH.
